// File: rtl/piradip_axis_sample_buffer_player_if.sv
// AXI-Stream master/slave bundle carrying buffer words out of the sample player.
// Latency: none, wires only. Backpressure: tready from the slave stalls the master's tvalid/tdata/tlast.
// Signals: tdata (DATA_WIDTH), tvalid, tlast driven by the master; tready driven by the slave.
interface piradip_axis_sample_buffer_player_if #(
  parameter int DATA_WIDTH = 128
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/piradip_axis_sample_buffer_player.sv
// Plays a start..end (inclusive, wrapping) window of a sample buffer out on AXI-Stream, once or looping.
// Latency: 3 cycles from stream_update to first m.tvalid (latch, read, buffer); 1 word/cycle sustained.
// Backpressure: reads stall once buffered + in-flight words would exceed the 2-entry skid buffer.
// Ports: stream_clk/stream_rstn clock and async active-low reset; stream_* control word and stream_stopped
// status; mem_en/mem_addr/mem_rdata synchronous buffer read port (1-cycle latency); m AXI-Stream master.
module piradip_axis_sample_buffer_player #(
  parameter int STREAM_OFFSET_WIDTH = 5,
  parameter int DATA_WIDTH          = 128
) (
  input  logic                           stream_clk,
  input  logic                           stream_rstn,
  input  logic                           stream_update,
  input  logic                           stream_active,
  input  logic                           stream_one_shot,
  input  logic [STREAM_OFFSET_WIDTH-1:0] stream_start_offset,
  input  logic [STREAM_OFFSET_WIDTH-1:0] stream_end_offset,
  output logic                           stream_stopped,
  output logic                           mem_en,
  output logic [STREAM_OFFSET_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0]          mem_rdata,
  piradip_axis_sample_buffer_player_if.master m
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t state, state_nxt;

  logic [STREAM_OFFSET_WIDTH-1:0] ptr, start_q, end_q, pend_start, pend_end;
  logic                           one_shot_q, pend_one_shot, pend_vld;
  logic                           rd_vld, rd_last;
  logic [1:0]                     buf_cnt, occ;
  logic [DATA_WIDTH-1:0]          buf_dat [2];
  logic [1:0]                     buf_last;
  logic                           tvalid, push, pop, shift, load0, load1;
  logic                           start_req, stop_req, at_end;

  assign start_req = stream_update & stream_active;
  assign stop_req  = stream_update & ~stream_active;
  assign at_end    = (ptr == end_q);

  assign tvalid = (buf_cnt != 2'd0);
  assign push   = rd_vld;
  assign pop    = tvalid & m.tready;

  // A word leaving the buffer this cycle frees its slot for a read issued
  // this cycle; without that credit the stream could not sustain 1 word/cycle.
  assign occ = buf_cnt + {1'b0, rd_vld} - {1'b0, pop};

  always_comb begin
    state_nxt = state;
    mem_en    = 1'b0;
    case (state)
      IDLE: begin
        if (start_req || pend_vld) state_nxt = RUN;
      end
      RUN: begin
        if (stop_req) begin
          state_nxt = DRAIN;
        end else if (occ < 2'd2) begin
          mem_en = 1'b1;
          if (at_end && one_shot_q) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (buf_cnt == 2'd0 && !rd_vld) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge stream_clk or negedge stream_rstn) begin
    if (!stream_rstn) begin
      state          <= IDLE;
      stream_stopped <= 1'b1;
    end else begin
      state          <= state_nxt;
      stream_stopped <= (state_nxt == IDLE);
    end
  end

  // Pass configuration, read pointer and the pending (next-pass) config.
  always_ff @(posedge stream_clk or negedge stream_rstn) begin
    if (!stream_rstn) begin
      ptr           <= '0;
      start_q       <= '0;
      end_q         <= '0;
      one_shot_q    <= 1'b0;
      pend_start    <= '0;
      pend_end      <= '0;
      pend_one_shot <= 1'b0;
      pend_vld      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_req) begin
            start_q    <= stream_start_offset;
            end_q      <= stream_end_offset;
            one_shot_q <= stream_one_shot;
            ptr        <= stream_start_offset;
            pend_vld   <= 1'b0;
          end else if (pend_vld) begin
            start_q    <= pend_start;
            end_q      <= pend_end;
            one_shot_q <= pend_one_shot;
            ptr        <= pend_start;
            pend_vld   <= 1'b0;
          end
        end
        RUN, DRAIN: begin
          if (mem_en) begin
            if (at_end && !one_shot_q) begin
              // Pass boundary: only a config stored before this cycle takes effect.
              if (pend_vld) begin
                start_q    <= pend_start;
                end_q      <= pend_end;
                one_shot_q <= pend_one_shot;
                ptr        <= pend_start;
                pend_vld   <= 1'b0;
              end else begin
                ptr <= start_q;
              end
            end else begin
              ptr <= ptr + 1'b1;
            end
          end
          if (start_req) begin
            pend_start    <= stream_start_offset;
            pend_end      <= stream_end_offset;
            pend_one_shot <= stream_one_shot;
            pend_vld      <= 1'b1;
          end else if (stop_req) begin
            pend_vld <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge stream_clk or negedge stream_rstn) begin
    if (!stream_rstn) begin
      rd_vld  <= 1'b0;
      rd_last <= 1'b0;
    end else begin
      rd_vld  <= mem_en;
      rd_last <= mem_en & at_end;
    end
  end

  // 2-entry skid buffer, head always in slot 0.
  assign shift = pop & (buf_cnt == 2'd2);
  assign load0 = push & ((buf_cnt == 2'd0) | (pop & (buf_cnt == 2'd1)));
  assign load1 = push & (((buf_cnt == 2'd1) & ~pop) | ((buf_cnt == 2'd2) & pop));

  always_ff @(posedge stream_clk or negedge stream_rstn) begin
    if (!stream_rstn) begin
      buf_cnt  <= 2'd0;
      buf_last <= 2'b00;
    end else begin
      buf_cnt <= buf_cnt + {1'b0, push} - {1'b0, pop};
      if (shift) buf_last[0] <= buf_last[1];
      if (load0) buf_last[0] <= rd_last;
      if (load1) buf_last[1] <= rd_last;
    end
  end

  // Payload carries no reset; it is only observed behind tvalid.
  always_ff @(posedge stream_clk) begin
    if (shift) buf_dat[0] <= buf_dat[1];
    if (load0) buf_dat[0] <= mem_rdata;
    if (load1) buf_dat[1] <= mem_rdata;
  end

  assign mem_addr = ptr;
  assign m.tvalid = tvalid;
  assign m.tdata  = buf_dat[0];
  assign m.tlast  = buf_last[0] & tvalid;

endmodule

// File: tb/tb_piradip_axis_sample_buffer_player.sv
module tb_piradip_axis_sample_buffer_player;
  localparam int SW = 5;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rstn;
  logic          update, active, one_shot;
  logic [SW-1:0] start_off, end_off;
  logic          stopped, mem_en;
  logic [SW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  piradip_axis_sample_buffer_player_if #(.DATA_WIDTH(DW)) axis ();

  piradip_axis_sample_buffer_player #(.STREAM_OFFSET_WIDTH(SW), .DATA_WIDTH(DW)) dut (
    .stream_clk(clk), .stream_rstn(rstn), .stream_update(update), .stream_active(active),
    .stream_one_shot(one_shot), .stream_start_offset(start_off), .stream_end_offset(end_off),
    .stream_stopped(stopped), .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .m(axis)
  );

  // Each buffer word encodes its own address so the stream order is readable from tdata.
  function automatic logic [DW-1:0] word_of(input logic [SW-1:0] a);
    return {16{3'b101, a}};
  endfunction

  always @(posedge clk) if (mem_en) mem_rdata <= word_of(mem_addr);

  // Model: expected stream as a list of passes, each pass start..end with wrap, last on end.
  typedef struct {logic [SW-1:0] addr; logic last;} exp_t;
  exp_t exp_q[$];
  logic [SW-1:0] got_addr[$];
  logic          got_last[$];

  int vec = 0;
  int err = 0;

  task automatic push_pass(input logic [SW-1:0] s, input logic [SW-1:0] e);
    logic [SW-1:0] a = s;
    for (int i = 0; i < 32; i++) begin
      exp_q.push_back('{addr: a, last: (a == e)});
      if (a == e) break;
      a = a + 5'd1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    vec++;
    if (act !== exp_v) begin
      err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // Per-cycle compare: stream order/content, AXI hold rule and read-issue occupancy.
  int            issued, delivered;
  logic          prev_stall;
  logic [DW-1:0] prev_dat;
  logic          prev_last;
  always @(negedge clk) begin
    logic pop;
    exp_t e;
    if (!rstn) begin
      issued = 0; delivered = 0; prev_stall = 1'b0;
    end else begin
      pop = axis.tvalid && axis.tready;
      if (prev_stall) begin
        vec++;
        if (!axis.tvalid || axis.tdata !== prev_dat || axis.tlast !== prev_last) begin
          err++;
          $display("FAIL axis_hold: got valid %0b addr %0d last %0b expected valid 1 addr %0d last %0b",
                   axis.tvalid, axis.tdata[SW-1:0], axis.tlast, prev_dat[SW-1:0], prev_last);
        end
      end
      if (mem_en) begin
        // A word accepted on the same cycle frees its slot.
        vec++;
        if (issued - delivered - (pop ? 1 : 0) >= 2) begin
          err++;
          $display("FAIL occupancy: got %0d words pending at read issue, expected < 2",
                   issued - delivered - (pop ? 1 : 0));
        end
      end
      if (pop) begin
        vec++;
        if (exp_q.size() == 0) begin
          err++;
          $display("FAIL unexpected_word: got addr %0d expected no word", axis.tdata[SW-1:0]);
        end else begin
          e = exp_q.pop_front();
          if (axis.tdata !== word_of(e.addr) || axis.tlast !== e.last) begin
            err++;
            $display("FAIL stream_word: got addr %0d last %0b expected addr %0d last %0b",
                     axis.tdata[SW-1:0], axis.tlast, e.addr, e.last);
          end
        end
        got_addr.push_back(axis.tdata[SW-1:0]);
        got_last.push_back(axis.tlast);
        delivered++;
      end
      if (mem_en) issued++;
      prev_stall = axis.tvalid && !axis.tready;
      prev_dat   = axis.tdata;
      prev_last  = axis.tlast;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic act, input logic os, input logic [SW-1:0] s, input logic [SW-1:0] e);
    update = 1'b1; active = act; one_shot = os; start_off = s; end_off = e;
    tick();
    update = 1'b0;
  endtask

  task automatic wait_stopped(input string name);
    int n = 0;
    while (!stopped && n < 200) begin
      tick();
      n++;
    end
    chk(name, {31'd0, stopped}, 32'd1);
  endtask

  task automatic clear_got();
    got_addr.delete();
    got_last.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [SW-1:0] lit_a [8];
    logic          lit_l [4];
    int            lat;

    rstn = 1'b0; update = 1'b0; active = 1'b0; one_shot = 1'b0;
    start_off = '0; end_off = '0; axis.tready = 1'b0;
    tick(); tick();
    chk("rst_tvalid",  {31'd0, axis.tvalid}, 32'd0);
    chk("rst_tlast",   {31'd0, axis.tlast},  32'd0);
    chk("rst_mem_en",  {31'd0, mem_en},      32'd0);
    chk("rst_mem_addr", {27'd0, mem_addr},   32'd0);
    chk("rst_stopped", {31'd0, stopped},     32'd1);
    rstn = 1'b1;
    tick();

    // One-shot 2..5, full-rate sink: latency, burst, literal order.
    clear_got();
    axis.tready = 1'b1;
    push_pass(5'd2, 5'd5);
    update = 1'b1; active = 1'b1; one_shot = 1'b1; start_off = 5'd2; end_off = 5'd5;
    lat = 0;
    do begin
      tick();
      update = 1'b0;
      lat++;
    end while (!axis.tvalid && lat < 20);
    chk("first_latency", lat, 32'd3);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("burst_valid", {31'd0, axis.tvalid}, 32'd1);
    end
    wait_stopped("oneshot_stop");
    chk("oneshot_len", got_addr.size(), 32'd4);
    lit_a = '{5'd2, 5'd3, 5'd4, 5'd5, 5'd0, 5'd0, 5'd0, 5'd0};
    lit_l = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4 && i < got_addr.size(); i++) begin
      chk("oneshot_addr", {27'd0, got_addr[i]}, {27'd0, lit_a[i]});
      chk("oneshot_last", {31'd0, got_last[i]}, {31'd0, lit_l[i]});
    end
    chk("oneshot_leftover", exp_q.size(), 32'd0);

    // Wrapping window 30..1.
    clear_got();
    push_pass(5'd30, 5'd1);
    strobe(1'b1, 1'b1, 5'd30, 5'd1);
    wait_stopped("wrap_stop");
    chk("wrap_len", got_addr.size(), 32'd4);
    lit_a = '{5'd30, 5'd31, 5'd0, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0};
    for (int i = 0; i < 4 && i < got_addr.size(); i++) begin
      chk("wrap_addr", {27'd0, got_addr[i]}, {27'd0, lit_a[i]});
      chk("wrap_last", {31'd0, got_last[i]}, {31'd0, lit_l[i]});
    end

    // Looping 0..3 under a random 50% sink.
    clear_got();
    for (int p = 0; p < 60; p++) push_pass(5'd0, 5'd3);
    strobe(1'b1, 1'b0, 5'd0, 5'd3);
    for (int i = 0; i < 200; i++) begin
      axis.tready = ($urandom_range(0, 1) == 1);
      tick();
    end
    axis.tready = 1'b1;
    strobe(1'b0, 1'b0, 5'd0, 5'd3);
    wait_stopped("loop_stop");
    chk("loop_progress", {31'd0, got_addr.size() >= 20}, 32'd1);
    exp_q.delete();

    // Looping 0..3, retarget to 8..9 mid-pass; full rate across short-loop wraps.
    clear_got();
    axis.tready = 1'b0;
    push_pass(5'd0, 5'd3);
    for (int p = 0; p < 30; p++) push_pass(5'd8, 5'd9);
    strobe(1'b1, 1'b0, 5'd0, 5'd3);
    repeat (5) tick();
    strobe(1'b1, 1'b0, 5'd8, 5'd9);
    axis.tready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      chk("retarget_rate", {31'd0, axis.tvalid}, 32'd1);
      tick();
    end
    strobe(1'b0, 1'b0, 5'd0, 5'd0);
    wait_stopped("retarget_stop");
    lit_a = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd8, 5'd9, 5'd8, 5'd9};
    for (int i = 0; i < 8 && i < got_addr.size(); i++)
      chk("retarget_addr", {27'd0, got_addr[i]}, {27'd0, lit_a[i]});
    exp_q.delete();

    // Stop while the sink is stalled: only the two buffered words come out.
    clear_got();
    axis.tready = 1'b0;
    for (int p = 0; p < 2; p++) push_pass(5'd0, 5'd3);
    strobe(1'b1, 1'b0, 5'd0, 5'd3);
    repeat (4) tick();
    strobe(1'b0, 1'b0, 5'd0, 5'd3);
    repeat (10) tick();
    chk("stall_none_out", got_addr.size(), 32'd0);
    chk("stall_not_stopped", {31'd0, stopped}, 32'd0);
    axis.tready = 1'b1;
    wait_stopped("stall_stop");
    chk("stall_drained", got_addr.size(), 32'd2);
    exp_q.delete();

    // Reset mid-run: outputs drop at once, block stays idle until a new update.
    axis.tready = 1'b1;
    for (int p = 0; p < 10; p++) push_pass(5'd0, 5'd3);
    strobe(1'b1, 1'b0, 5'd0, 5'd3);
    repeat (6) tick();
    #2 rstn = 1'b0;
    #1;
    chk("arst_tvalid",  {31'd0, axis.tvalid}, 32'd0);
    chk("arst_tlast",   {31'd0, axis.tlast},  32'd0);
    chk("arst_stopped", {31'd0, stopped},     32'd1);
    chk("arst_mem_en",  {31'd0, mem_en},      32'd0);
    tick(); tick();
    rstn = 1'b1;
    exp_q.delete();
    clear_got();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("post_rst_idle_valid",   {31'd0, axis.tvalid}, 32'd0);
      chk("post_rst_idle_stopped", {31'd0, stopped},     32'd1);
    end

    // Single-word pass after reset.
    push_pass(5'd7, 5'd7);
    strobe(1'b1, 1'b1, 5'd7, 5'd7);
    wait_stopped("single_stop");
    chk("single_len", got_addr.size(), 32'd1);
    if (got_addr.size() > 0) begin
      chk("single_addr", {27'd0, got_addr[0]}, 32'd7);
      chk("single_last", {31'd0, got_last[0]}, 32'd1);
    end

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule

// File: doc/piradip_axis_sample_buffer_player.md
PIRADIP_AXIS_SAMPLE_BUFFER_PLAYER -- requirements
Module: piradip_axis_sample_buffer_player

Interface
REQ-001 Parameter STREAM_OFFSET_WIDTH, default 5, SHALL set the buffer word-address width, giving a depth of 2^STREAM_OFFSET_WIDTH words.
REQ-002 Parameter DATA_WIDTH, default 128, SHALL set the width of the buffer word and of m_tdata.
REQ-003 stream_clk  in  1  the single clock; every state element is clocked on its rising edge.
REQ-004 stream_rstn  in  1  reset, asynchronous and active-low.
REQ-005 stream_update  in  1  one-cycle strobe; the stream_* control word below is valid on this cycle.
REQ-006 stream_active  in  1  sampled on stream_update; 1 requests run, 0 requests stop.
REQ-007 stream_one_shot  in  1  sampled on stream_update; 1 requests a single pass, 0 requests looping.
REQ-008 stream_start_offset  in  STREAM_OFFSET_WIDTH  first word address of a pass.
REQ-009 stream_end_offset  in  STREAM_OFFSET_WIDTH  last word address of a pass, inclusive.
REQ-010 stream_stopped  out  1  1 when the block is idle with no data in flight.
REQ-011 mem_en  out  1  buffer read enable.
REQ-012 mem_addr  out  STREAM_OFFSET_WIDTH  buffer read address.
REQ-013 mem_rdata  in  DATA_WIDTH  buffer read data, valid exactly 1 cycle after a cycle with mem_en=1.
REQ-014 m_tdata, m_tvalid, m_tlast  out  DATA_WIDTH/1/1  AXI-Stream master output.
REQ-015 m_tready  in  1  AXI-Stream backpressure.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN and DRAIN.
REQ-017 IDLE + stream_update with stream_active=1 SHALL latch start, end and one_shot, set the read pointer to start, and enter RUN on the next cycle.
REQ-018 In RUN, mem_en SHALL be 1 only when (words held in the output buffer + reads in flight) < 2; the output buffer is a 2-entry skid buffer, which prevents overflow under any m_tready pattern.
REQ-019 Each issued read SHALL advance the pointer by 1 modulo 2^STREAM_OFFSET_WIDTH, and the read at pointer==end SHALL be tagged last.
REQ-020 start > end SHALL be legal and SHALL give a pass that wraps through address 2^W-1 to 0; start == end SHALL give a one-word pass.
REQ-021 After the last-tagged read: with one_shot=1 the block SHALL enter DRAIN; with one_shot=0 it SHALL reload the pointer from the latched start, and a pending config becomes active at this point.
REQ-022 stream_update with stream_active=1 during RUN SHALL store start, end and one_shot as a pending config, applied only at the next pass boundary, so the current pass is never truncated.
REQ-023 stream_update with stream_active=0 during RUN SHALL stop further read issue immediately and enter DRAIN; the words already read SHALL still be delivered.
REQ-024 DRAIN SHALL go to IDLE on the cycle after the buffer and in-flight reads are both empty; in DRAIN, stream_update with active=1 SHALL be held pending and taken in IDLE on the next cycle.
REQ-025 m_tvalid/m_tdata/m_tlast SHALL obey AXI-Stream: once m_tvalid is asserted, all three SHALL hold stable until m_tready=1, and data SHALL be emitted in issue order with no loss or duplication.
REQ-026 stream_stopped SHALL be 1 in IDLE and 0 in RUN and DRAIN, and SHALL be registered.
REQ-027 Minimum latency SHALL be 3 cycles, measured from the stream_update strobe to the first m_tvalid (latch, read, buffer), with m_tready held at 1.
REQ-028 With m_tready=1 continuously, throughput SHALL be one word per cycle, including across loop wrap.

Reset
REQ-029 While stream_rstn=0: state=IDLE, m_tvalid=0, m_tlast=0, mem_en=0, mem_addr=0, stream_stopped=1, buffer and in-flight counters=0, pending config cleared.
REQ-030 Reset asserted mid-RUN SHALL drop all buffered words and discard in-flight reads; after release the block SHALL remain in IDLE until a new stream_update.
REQ-031 m_tdata SHALL be don't-care in reset.

Verification
REQ-032 W=5, start=2, end=5, one_shot=1, m_tready=1 -> words @2,3,4,5 on consecutive cycles, tlast on @5 only, then stream_stopped=1.
REQ-033 start=30, end=1, one_shot=1 -> order 30,31,0,1, tlast on @1.
REQ-034 start=0, end=3, looping, m_tready random 50% -> 0,1,2,3,0,1,... with no gaps or duplicates, tlast every 4th word, mem_en never issued with 2 words pending.
REQ-035 Looping 0..3, then an update to start=8, end=9 mid-pass -> current pass completes at @3, then 8,9,8,...
REQ-036 Update with active=0 while running and m_tready=0 for 10 cycles -> at most 2 words delivered after m_tready rises, then stream_stopped=1.
REQ-037 Reset pulse mid-RUN -> m_tvalid=0 and stream_stopped=1 asynchronously; no output until the next update.
